// File: rtl/stb_req_arbiter_pkg.sv
// ----------------------------------------------------------------------------
// stb_arb_pkg
// Shared definitions for stb_req_arbiter:
//   - state_t    : arbiter FSM encoding (IDLE/ISSUE/GAP)
//   - cmd_w()    : width of one packed requester command
//   - off_*()    : bit offsets of each field inside a packed command
// Packed command layout, LSB upward:
//   ur_addr | ur_id | gr_base_addr | brst | byte_strb | smc_strb
// ----------------------------------------------------------------------------
package stb_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    GAP   = 2'd2
  } state_t;

  localparam int BYTE_STRB_W = 4;

  function automatic int cmd_w(input int smc_count, input int burst_width,
                               input int addr_width, input int ur_id_width,
                               input int ur_addr_width);
    return smc_count + BYTE_STRB_W + burst_width + addr_width + ur_id_width + ur_addr_width;
  endfunction

  localparam int OFF_UR_ADDR = 0;

  function automatic int off_ur_id(input int ur_addr_width);
    return ur_addr_width;
  endfunction

  function automatic int off_gr_base(input int ur_addr_width, input int ur_id_width);
    return ur_addr_width + ur_id_width;
  endfunction

  function automatic int off_brst(input int ur_addr_width, input int ur_id_width,
                                  input int addr_width);
    return ur_addr_width + ur_id_width + addr_width;
  endfunction

  function automatic int off_byte_strb(input int ur_addr_width, input int ur_id_width,
                                       input int addr_width, input int burst_width);
    return ur_addr_width + ur_id_width + addr_width + burst_width;
  endfunction

  function automatic int off_smc_strb(input int ur_addr_width, input int ur_id_width,
                                      input int addr_width, input int burst_width);
    return ur_addr_width + ur_id_width + addr_width + burst_width + BYTE_STRB_W;
  endfunction

endpackage

// File: rtl/stb_req_arbiter_if.sv
// ----------------------------------------------------------------------------
// stb_arb_if
// Bundles the requester side, the burst_store upstream command side and the
// status/debug outputs of stb_req_arbiter.
//   slave  : the arbiter's view
//   master : the environment's view (requesters + burst_store + observers)
//
// Handshake rules:
//   - Requester i holds req_valid[i] with a stable slot in req_cmd until it
//     sees req_ready[i]; a transfer happens on the clock edge where both are
//     high. Dropping req_valid before that edge is legal and has no effect.
//     req_ready is one-hot (or zero) and combinational from req_valid.
//   - stb_u_valid stays high with stable fields until the burst_store returns
//     stb_d_done; stb_d_done is only meaningful while stb_u_valid is high.
//   - req_done[i] is a one-cycle pulse to the requester that owned the burst.
// ----------------------------------------------------------------------------
interface stb_arb_if
  import stb_arb_pkg::*;
#(
  parameter int NUM_REQ       = 4,
  parameter int SMC_COUNT     = 4,
  parameter int BURST_WIDTH   = 8,
  parameter int ADDR_WIDTH    = 32,
  parameter int UR_ID_WIDTH   = 3,
  parameter int UR_ADDR_WIDTH = 11
) ();

  localparam int CMD_W = cmd_w(SMC_COUNT, BURST_WIDTH, ADDR_WIDTH, UR_ID_WIDTH, UR_ADDR_WIDTH);
  localparam int PW    = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]       req_valid;
  logic [NUM_REQ*CMD_W-1:0] req_cmd;
  logic [NUM_REQ-1:0]       req_ready;
  logic [NUM_REQ-1:0]       req_done;

  logic                     stb_u_valid;
  logic [SMC_COUNT-1:0]     stb_u_smc_strb;
  logic [BYTE_STRB_W-1:0]   stb_u_byte_strb;
  logic [BURST_WIDTH-1:0]   stb_u_brst;
  logic [ADDR_WIDTH-1:0]    stb_u_gr_base_addr;
  logic [UR_ID_WIDTH-1:0]   stb_u_ur_id;
  logic [UR_ADDR_WIDTH-1:0] stb_u_ur_addr;
  logic                     stb_d_done;

  logic                     busy;
  logic [PW-1:0]            owner;
  logic                     arb_err;
  state_t                   dbg_state;
  logic [PW-1:0]            dbg_rr_ptr;

  modport slave (
    input  req_valid, req_cmd, stb_d_done,
    output req_ready, req_done,
           stb_u_valid, stb_u_smc_strb, stb_u_byte_strb, stb_u_brst,
           stb_u_gr_base_addr, stb_u_ur_id, stb_u_ur_addr,
           busy, owner, arb_err, dbg_state, dbg_rr_ptr
  );

  modport master (
    output req_valid, req_cmd, stb_d_done,
    input  req_ready, req_done,
           stb_u_valid, stb_u_smc_strb, stb_u_byte_strb, stb_u_brst,
           stb_u_gr_base_addr, stb_u_ur_id, stb_u_ur_addr,
           busy, owner, arb_err, dbg_state, dbg_rr_ptr
  );

endinterface

// File: rtl/stb_req_arbiter_rr.sv
// ----------------------------------------------------------------------------
// rr_arbiter
// Combinational round-robin pick: the first asserted req bit found when
// searching ptr, ptr+1, ... wrapping modulo NUM_REQ.
// Ports:
//   req     in  NUM_REQ  request vector
//   ptr     in  PW       highest-priority index for this pick
//   gnt     out NUM_REQ  one-hot grant (zero when no request)
//   gnt_idx out PW       index of the granted bit (0 when no request)
//   any     out 1        at least one request present
// ----------------------------------------------------------------------------
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int PW      = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PW-1:0]      ptr,
  output logic [NUM_REQ-1:0] gnt,
  output logic [PW-1:0]      gnt_idx,
  output logic               any
);

  int idx;

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    any     = 1'b0;
    idx     = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = (int'(ptr) + k) % NUM_REQ;
      if (!any && req[idx]) begin
        any      = 1'b1;
        gnt[idx] = 1'b1;
        gnt_idx  = PW'(idx);
      end
    end
  end

endmodule

// File: rtl/stb_req_arbiter.sv
// ----------------------------------------------------------------------------
// stb_req_arbiter
// Shares one burst_store engine among NUM_REQ store requesters. In IDLE the
// round-robin winner is accepted combinationally, its command is latched and
// presented to burst_store (ISSUE) until stb_d_done; then one GAP cycle with
// stb_u_valid low lets burst_store re-arm, during which req_done pulses to
// the owner.
// Ports:
//   clk    in  clock
//   rst_n  in  asynchronous active-low reset (drops stb_u_valid at once,
//              no req_done for an interrupted burst)
//   bus    stb_arb_if.slave: requester handshake, burst_store command,
//          busy/owner/arb_err status and dbg_state/dbg_rr_ptr debug view
// Optional feature macro: STB_ARB_TIMEOUT_EN
//   When defined, a burst still pending after TIMEOUT_CYCLES ISSUE cycles is
//   aborted: arb_err and req_done[owner] pulse, and the arbiter moves on.
//   When undefined, ISSUE waits indefinitely and arb_err stays 0.
// ----------------------------------------------------------------------------
module stb_req_arbiter
  import stb_arb_pkg::*;
#(
  parameter int NUM_REQ        = 4,
  parameter int SMC_COUNT      = 4,
  parameter int BURST_WIDTH    = 8,
  parameter int ADDR_WIDTH     = 32,
  parameter int UR_ID_WIDTH    = 3,
  parameter int UR_ADDR_WIDTH  = 11,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic     clk,
  input  logic     rst_n,
  stb_arb_if.slave bus
);

  localparam int CMD_W    = cmd_w(SMC_COUNT, BURST_WIDTH, ADDR_WIDTH, UR_ID_WIDTH, UR_ADDR_WIDTH);
  localparam int PW       = $clog2(NUM_REQ);
  localparam int OFF_ID   = off_ur_id(UR_ADDR_WIDTH);
  localparam int OFF_GR   = off_gr_base(UR_ADDR_WIDTH, UR_ID_WIDTH);
  localparam int OFF_BRST = off_brst(UR_ADDR_WIDTH, UR_ID_WIDTH, ADDR_WIDTH);
  localparam int OFF_BYTE = off_byte_strb(UR_ADDR_WIDTH, UR_ID_WIDTH, ADDR_WIDTH, BURST_WIDTH);
  localparam int OFF_SMC  = off_smc_strb(UR_ADDR_WIDTH, UR_ID_WIDTH, ADDR_WIDTH, BURST_WIDTH);

  state_t             state_q, state_d;
  logic [PW-1:0]      rr_ptr_q, rr_ptr_d;
  logic [PW-1:0]      owner_q, owner_d;
  logic [CMD_W-1:0]   cmd_q, cmd_d;
  logic [NUM_REQ-1:0] done_q, done_d;
  logic               err_q, err_d;
  logic [NUM_REQ-1:0] ready;

  logic [NUM_REQ-1:0] gnt;
  logic [PW-1:0]      gnt_idx;
  logic               gnt_any;
  logic [CMD_W-1:0]   sel_cmd;
  logic               expire;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .PW      (PW)
  ) u_rr (
    .req     (bus.req_valid),
    .ptr     (rr_ptr_q),
    .gnt     (gnt),
    .gnt_idx (gnt_idx),
    .any     (gnt_any)
  );

  assign sel_cmd = bus.req_cmd[gnt_idx*CMD_W +: CMD_W];

`ifdef STB_ARB_TIMEOUT_EN
  // Counts ISSUE cycles; zero on the first ISSUE cycle, so expiry is seen
  // on the TIMEOUT_CYCLES-th cycle of the burst.
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES) + 1;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = '0;
    if (state_q == ISSUE) cnt_d = cnt_q + CNT_W'(1);
  end

  assign expire = (state_q == ISSUE) && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end
`else
  assign expire = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    owner_d  = owner_q;
    cmd_d    = cmd_q;
    done_d   = '0;
    err_d    = 1'b0;
    ready    = '0;
    unique case (state_q)
      IDLE: begin
        if (gnt_any) begin
          ready   = gnt;
          cmd_d   = sel_cmd;
          owner_d = gnt_idx;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        // A done coinciding with expiry is a normal completion.
        if (bus.stb_d_done || expire) begin
          state_d  = GAP;
          done_d   = NUM_REQ'(1) << owner_q;
          err_d    = !bus.stb_d_done;
          // The finished owner ranks last in the next search.
          rr_ptr_d = (owner_q == PW'(NUM_REQ - 1)) ? '0 : owner_q + PW'(1);
        end
      end
      GAP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      rr_ptr_q <= '0;
      owner_q  <= '0;
      cmd_q    <= '0;
      done_q   <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      owner_q  <= owner_d;
      cmd_q    <= cmd_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  assign bus.req_ready          = ready;
  assign bus.req_done           = done_q;
  assign bus.stb_u_valid        = (state_q == ISSUE);
  assign bus.stb_u_ur_addr      = cmd_q[OFF_UR_ADDR +: UR_ADDR_WIDTH];
  assign bus.stb_u_ur_id        = cmd_q[OFF_ID      +: UR_ID_WIDTH];
  assign bus.stb_u_gr_base_addr = cmd_q[OFF_GR      +: ADDR_WIDTH];
  assign bus.stb_u_brst         = cmd_q[OFF_BRST    +: BURST_WIDTH];
  assign bus.stb_u_byte_strb    = cmd_q[OFF_BYTE    +: BYTE_STRB_W];
  assign bus.stb_u_smc_strb     = cmd_q[OFF_SMC     +: SMC_COUNT];
  assign bus.busy               = (state_q != IDLE);
  assign bus.owner              = owner_q;
  assign bus.arb_err            = err_q;
  assign bus.dbg_state          = state_q;
  assign bus.dbg_rr_ptr         = rr_ptr_q;

endmodule

// File: tb/tb_stb_req_arbiter.sv
// ----------------------------------------------------------------------------
// tb_stb_req_arbiter
// Directed bench for stb_req_arbiter at default widths (TIMEOUT_CYCLES=16).
// Expected commands/owners are queued when a grant is expected and popped
// when the burst appears on the burst_store side. Outputs are sampled on the
// falling clock edge; the DUT acts on the rising edge.
// ----------------------------------------------------------------------------
module tb_stb_req_arbiter;
  import stb_arb_pkg::*;

  localparam int NUM_REQ = 4;
  localparam int CMD_W   = 62;

  logic clk;
  logic rst_n;

  stb_arb_if #(
    .NUM_REQ(NUM_REQ), .SMC_COUNT(4), .BURST_WIDTH(8), .ADDR_WIDTH(32),
    .UR_ID_WIDTH(3), .UR_ADDR_WIDTH(11)
  ) bus ();

  stb_req_arbiter #(
    .NUM_REQ(NUM_REQ), .SMC_COUNT(4), .BURST_WIDTH(8), .ADDR_WIDTH(32),
    .UR_ID_WIDTH(3), .UR_ADDR_WIDTH(11), .TIMEOUT_CYCLES(16)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  logic [CMD_W-1:0] exp_q[$];
  int               exp_own_q[$];
  logic [CMD_W-1:0] slot_cmd[NUM_REQ];

  function automatic logic [CMD_W-1:0] mk_cmd(input logic [3:0] smc, input logic [3:0] bs,
                                              input logic [7:0] brst, input logic [31:0] base,
                                              input logic [2:0] id, input logic [10:0] ua);
    return {smc, bs, brst, base, id, ua};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [CMD_W-1:0] obs_cmd();
    return {bus.stb_u_smc_strb, bus.stb_u_byte_strb, bus.stb_u_brst,
            bus.stb_u_gr_base_addr, bus.stb_u_ur_id, bus.stb_u_ur_addr};
  endfunction

  task automatic load_slots();
    for (int i = 0; i < NUM_REQ; i++) bus.req_cmd[i*CMD_W +: CMD_W] = slot_cmd[i];
  endtask

  // Called at an IDLE sampling point with req_valid already driven.
  task automatic expect_grant(input int idx);
    #1;
    chk("req_ready_grant", bus.req_ready, 64'(1) << idx);
    exp_q.push_back(slot_cmd[idx]);
    exp_own_q.push_back(idx);
  endtask

  // Waits (bounded) for the burst and checks it against the scoreboard.
  task automatic wait_issue(output int own);
    int n;
    logic [CMD_W-1:0] ec;
    n = 0;
    own = 0;
    @(negedge clk);
    while (!bus.stb_u_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("issue_latency", 64'(n), 64'(0));
    chk("stb_u_valid_issue", bus.stb_u_valid, 1);
    chk("sb_nonempty", 64'(exp_q.size() != 0), 1);
    if (exp_q.size() != 0) begin
      ec  = exp_q.pop_front();
      own = exp_own_q.pop_front();
      chk("stb_u_fields", obs_cmd(), ec);
      chk("owner", bus.owner, own);
    end
    chk("ready_in_issue", bus.req_ready, 0);
    chk("busy_issue", bus.busy, 1);
  endtask

  // Holds ISSUE for extra cycles, returns done, checks GAP and return to IDLE.
  task automatic finish_burst(input int own, input int extra, input bit spurious);
    repeat (extra) begin
      @(negedge clk);
      chk("hold_valid", bus.stb_u_valid, 1);
      chk("hold_no_done", bus.req_done, 0);
    end
    bus.stb_d_done = 1'b1;
    @(negedge clk);
    if (!spurious) bus.stb_d_done = 1'b0;
    chk("req_done_pulse", bus.req_done, 64'(1) << own);
    chk("gap_valid_low", bus.stb_u_valid, 0);
    chk("gap_state", bus.dbg_state, 64'(GAP));
    chk("gap_no_ready", bus.req_ready, 0);
    chk("gap_arb_err", bus.arb_err, 0);
    @(negedge clk);
    bus.stb_d_done = 1'b0;
    chk("done_one_cycle", bus.req_done, 0);
    chk("idle_state", bus.dbg_state, 64'(IDLE));
    chk("idle_valid_low", bus.stb_u_valid, 0);
    chk("rr_ptr_adv", bus.dbg_rr_ptr, (own + 1) % NUM_REQ);
  endtask

  initial begin
    int own;
    int cnt;
    rst_n          = 1'b0;
    bus.req_valid  = '0;
    bus.req_cmd    = '0;
    bus.stb_d_done = 1'b0;
    slot_cmd[0] = mk_cmd(4'(($urandom_range(1, 15))), 4'hF, 8'($urandom_range(1, 255)),
                         $urandom, 3'($urandom_range(0, 7)), 11'($urandom_range(0, 2047)));
    slot_cmd[1] = mk_cmd(4'h5, 4'h3, 8'($urandom_range(1, 255)), $urandom, 3'd5,
                         11'($urandom_range(0, 2047)));
    slot_cmd[2] = mk_cmd(4'hA, 4'hC, 8'd4, 32'h0000_1000, 3'd0, 11'h123);
    // zero brst and smc_strb must be forwarded unchanged
    slot_cmd[3] = mk_cmd(4'h0, 4'h1, 8'd0, $urandom, 3'd7, 11'($urandom_range(0, 2047)));
    load_slots();

    // reset state
    repeat (3) @(negedge clk);
    chk("rst_busy", bus.busy, 0);
    chk("rst_valid", bus.stb_u_valid, 0);
    chk("rst_ready", bus.req_ready, 0);
    chk("rst_done", bus.req_done, 0);
    chk("rst_owner", bus.owner, 0);
    chk("rst_fields", obs_cmd(), 0);
    chk("rst_state", bus.dbg_state, 64'(IDLE));
    chk("rst_rr_ptr", bus.dbg_rr_ptr, 0);
    chk("rst_arb_err", bus.arb_err, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // single request from requester 2
    bus.req_valid = 4'b0100;
    expect_grant(2);
    wait_issue(own);
    bus.req_valid = '0;
    finish_burst(own, 2, 1'b0);

    // done while IDLE is ignored
    bus.stb_d_done = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("spur_idle_state", bus.dbg_state, 64'(IDLE));
      chk("spur_idle_done", bus.req_done, 0);
    end
    bus.stb_d_done = 1'b0;

    // reset during ISSUE, owner 1 (ptr=3 searches 3,0,1)
    bus.req_valid = 4'b0010;
    expect_grant(1);
    wait_issue(own);
    bus.req_valid = '0;
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mid_valid", bus.stb_u_valid, 0);
    chk("rst_mid_busy", bus.busy, 0);
    @(negedge clk);
    chk("rst_mid_no_done", bus.req_done, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_state", bus.dbg_state, 64'(IDLE));
    chk("post_rst_rr_ptr", bus.dbg_rr_ptr, 0);
    chk("post_rst_no_done", bus.req_done, 0);

    // round robin with all requesters valid: 0,1,2,3
    bus.req_valid = 4'hF;
    for (int i = 0; i < NUM_REQ; i++) begin
      expect_grant(i);
      wait_issue(own);
      finish_burst(own, $urandom_range(0, 3), i == 1);
    end

    // pointer wrapped to 0: only 1 and 3 valid -> 1 before 3
    bus.req_valid = 4'b1010;
    expect_grant(1);
    wait_issue(own);
    finish_burst(own, 0, 1'b0);
    expect_grant(3);
    wait_issue(own);
    bus.req_valid = 4'hF;
    finish_burst(own, 1, 1'b0);

    // back to all valid after 3 finished -> 0
    expect_grant(0);
    wait_issue(own);
    bus.req_valid = '0;
    finish_burst(own, 0, 1'b0);

`ifdef STB_ARB_TIMEOUT_EN
    // watchdog: no done for requester 2, then requester 3 is served
    bus.req_valid = 4'b0100;
    expect_grant(2);
    wait_issue(own);
    bus.req_valid = 4'b1001;
    cnt = 1;
    for (int k = 0; k < 40 && bus.stb_u_valid; k++) begin
      @(negedge clk);
      if (bus.stb_u_valid) cnt++;
    end
    chk("to_issue_cycles", 64'(cnt), 16);
    chk("to_arb_err", bus.arb_err, 1);
    chk("to_req_done", bus.req_done, 64'(1) << 2);
    chk("to_gap_state", bus.dbg_state, 64'(GAP));
    @(negedge clk);
    chk("to_err_pulse", bus.arb_err, 0);
    chk("to_rr_ptr", bus.dbg_rr_ptr, 3);
    expect_grant(3);
    wait_issue(own);
    bus.req_valid = '0;
    finish_burst(own, 0, 1'b0);
`else
    cnt = 0;
    chk("no_timeout_arb_err", bus.arb_err, 64'(cnt));
`endif

    chk("sb_drained", 64'(exp_q.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
